// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin collector of FU results into a FIFO that drains into the regfile write port
// Optional feature macro: WB_FWD_EN, which enables lookup of buffered writes on lk_rsel1/lk_rsel2.
// Ports:
//   CLK, nRST                   clock (rising edge), asynchronous active-low reset
//   src_valid/src_ready         per-source handshake; src_ready is one-hot or zero
//   src_rd/src_data             per-source destination register and result, packed source-major
//   stall                       holds the FIFO head back from the regfile
//   WEN/wsel/wdata              regfile write port, driven from the FIFO head
//   pending                     FIFO holds at least one entry
//   lk_rsel1/2 -> lk_hit1/2, lk_data1/2   youngest buffered write per index (WB_FWD_EN only)
module regfile_wb_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*ADDR_W-1:0] src_rd,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      stall,
  output logic                      WEN,
  output logic [ADDR_W-1:0]         wsel,
  output logic [DATA_W-1:0]         wdata,
  output logic                      pending,
  input  logic [ADDR_W-1:0]         lk_rsel1,
  input  logic [ADDR_W-1:0]         lk_rsel2,
  output logic                      lk_hit1,
  output logic                      lk_hit2,
  output logic [DATA_W-1:0]         lk_data1,
  output logic [DATA_W-1:0]         lk_data2
);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = $clog2(NUM_SRC);
  logic [ADDR_W-1:0] r_rd_mem [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [PW:0]       r_count;
  logic [SW-1:0]     r_rr_ptr;
  logic              w_gnt_vld, w_full, w_acc, w_push, w_empty;
  logic [SW-1:0]     w_gnt;
  logic [ADDR_W-1:0] w_gnt_rd;
  logic [DATA_W-1:0] w_gnt_data;
  // Scan from rr_ptr+NUM_SRC down to rr_ptr+1 so the highest-priority valid source is assigned last.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt = '0;
    for (int i = NUM_SRC; i >= 1; i--)
      if (src_valid[(int'(r_rr_ptr) + i) % NUM_SRC]) begin
        w_gnt_vld = 1'b1;
        w_gnt = SW'((int'(r_rr_ptr) + i) % NUM_SRC);
      end
  end
  assign w_gnt_rd   = src_rd[int'(w_gnt)*ADDR_W +: ADDR_W];
  assign w_gnt_data = src_data[int'(w_gnt)*DATA_W +: DATA_W];
  assign w_full     = r_count == (PW+1)'(DEPTH);
  assign w_empty    = r_count == '0;
  // Ready is held low while in reset so nothing appears accepted before the FIFO exists.
  assign w_acc      = nRST && w_gnt_vld && !w_full;
  // Results for x0 are consumed but never reach the FIFO.
  assign w_push     = w_acc && (w_gnt_rd != '0);
  assign src_ready  = w_acc ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << w_gnt) : '0;
  assign WEN        = !w_empty && !stall;
  assign wsel       = w_empty ? '0 : r_rd_mem[r_rd_ptr];
  assign wdata      = w_empty ? '0 : r_data_mem[r_rd_ptr];
  assign pending    = !w_empty;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rd_mem[i]   <= '0;
        r_data_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rr_ptr <= SW'(NUM_SRC - 1);
    end else begin
      if (w_acc) r_rr_ptr <= w_gnt;
      if (w_push) begin
        r_rd_mem[r_wr_ptr]   <= w_gnt_rd;
        r_data_mem[r_wr_ptr] <= w_gnt_data;
        r_wr_ptr             <= r_wr_ptr + 1'b1;
      end
      if (WEN) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, WEN};
    end
  end
`ifdef WB_FWD_EN
  logic [PW-1:0] w_fidx;
  // Walk entries oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    lk_hit1 = 1'b0;
    lk_hit2 = 1'b0;
    lk_data1 = '0;
    lk_data2 = '0;
    w_fidx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_fidx = r_rd_ptr + PW'(i);
      if ((PW+1)'(i) < r_count && lk_rsel1 != '0 && r_rd_mem[w_fidx] == lk_rsel1) begin
        lk_hit1 = 1'b1;
        lk_data1 = r_data_mem[w_fidx];
      end
      if ((PW+1)'(i) < r_count && lk_rsel2 != '0 && r_rd_mem[w_fidx] == lk_rsel2) begin
        lk_hit2 = 1'b1;
        lk_data2 = r_data_mem[w_fidx];
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{lk_rsel1, lk_rsel2};
  assign lk_hit1  = 1'b0;
  assign lk_hit2  = 1'b0;
  assign lk_data1 = '0;
  assign lk_data2 = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic        CLK, nRST, stall, WEN, pending, lk_hit1, lk_hit2;
  logic [2:0]  src_valid, src_ready;
  logic [14:0] src_rd;
  logic [95:0] src_data;
  logic [4:0]  wsel, lk_rsel1, lk_rsel2;
  logic [31:0] wdata, lk_data1, lk_data2;
  int n_cmp = 0;
  int n_fail = 0;
  regfile_wb_arbiter dut (
    .CLK(CLK), .nRST(nRST), .src_valid(src_valid), .src_ready(src_ready),
    .src_rd(src_rd), .src_data(src_data), .stall(stall), .WEN(WEN), .wsel(wsel),
    .wdata(wdata), .pending(pending), .lk_rsel1(lk_rsel1), .lk_rsel2(lk_rsel2),
    .lk_hit1(lk_hit1), .lk_hit2(lk_hit2), .lk_data1(lk_data1), .lk_data2(lk_data2)
  );
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic set_src(input int s, input logic v, input logic [4:0] rd, input logic [31:0] d);
    src_valid[s] = v;
    src_rd[s*5 +: 5] = rd;
    src_data[s*32 +: 32] = d;
  endtask
  initial begin
    nRST = 1'b0;
    stall = 1'b0;
    src_valid = '0;
    src_rd = '0;
    src_data = '0;
    lk_rsel1 = '0;
    lk_rsel2 = '0;
    #2;
    chk("rst_wen", WEN, 0);
    chk("rst_pending", pending, 0);
    chk("rst_ready", src_ready, 0);
    chk("rst_wsel", wsel, 0);
    chk("rst_wdata", wdata, 0);
    #10 nRST = 1'b1;
    tick();
    // fairness: rr_ptr starts at NUM_SRC-1, so grants run 0,1,2,0,1,2
    for (int s = 0; s < 3; s++) set_src(s, 1'b1, 5'(s + 1), 32'h100 + 32'(s));
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("fair_ready%0d", k), src_ready, 64'(3'b001 << (k % 3)));
      if (k > 0) begin
        chk($sformatf("fair_wen%0d", k), WEN, 1);
        chk($sformatf("fair_wsel%0d", k), wsel, 64'((k - 1) % 3 + 1));
      end
      tick();
    end
    src_valid = '0;
    #1;
    chk("fair_last_wsel", wsel, 3);
    tick();
    chk("fair_drained", pending, 0);
    // single write
    set_src(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    chk("t1_ready", src_ready, 3'b001);
    chk("t1_wen_before", WEN, 0);
    tick();
    src_valid = '0;
    #1;
    chk("t1_wen", WEN, 1);
    chk("t1_wsel", wsel, 5);
    chk("t1_wdata", wdata, 32'hDEAD_BEEF);
    chk("t1_pending", pending, 1);
    tick();
    chk("t1_pending_after", pending, 0);
    chk("t1_wen_after", WEN, 0);
    // full + stall with six distinct rds from src1
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_src(1, 1'b1, 5'(10 + i), 32'hA0 + 32'(i));
      #1;
      chk($sformatf("t3_ready%0d", i), src_ready, 3'b010);
      tick();
    end
    set_src(1, 1'b1, 5'd14, 32'hA4);
    #1;
    chk("t3_full_ready", src_ready, 0);
    chk("t3_stall_wen", WEN, 0);
    chk("t3_pending", pending, 1);
    tick();
    chk("t3_full_ready2", src_ready, 0);
    stall = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("t3_wen%0d", k), WEN, 1);
      chk($sformatf("t3_wsel%0d", k), wsel, 64'(10 + k));
      chk($sformatf("t3_wdata%0d", k), wdata, 64'(32'hA0 + k));
      chk($sformatf("t3_rdy%0d", k), src_ready, (k == 1 || k == 2) ? 3'b010 : 3'b000);
      tick();
      if (k == 1) set_src(1, 1'b1, 5'd15, 32'hA5);
      if (k == 2) src_valid = '0;
    end
    chk("t3_drained", pending, 0);
    // x0 drop
    set_src(2, 1'b1, 5'd0, 32'h1234);
    #1;
    chk("t4_ready", src_ready, 3'b100);
    tick();
    src_valid = '0;
    #1;
    chk("t4_pending", pending, 0);
    chk("t4_wen", WEN, 0);
    tick();
    chk("t4_wen2", WEN, 0);
    // forwarding lookup, youngest rd=7 entry wins
    stall = 1'b1;
    set_src(0, 1'b1, 5'd7, 32'hAAAA);
    #1;
    chk("t6_ready_a", src_ready, 3'b001);
    tick();
    set_src(0, 1'b1, 5'd7, 32'hBBBB);
    tick();
    src_valid = '0;
    lk_rsel1 = 5'd7;
    lk_rsel2 = 5'd8;
    #1;
    chk("t6_hit1", lk_hit1, FWD ? 64'd1 : 64'd0);
    chk("t6_data1", lk_data1, FWD ? 64'hBBBB : 64'd0);
    chk("t6_hit2", lk_hit2, 0);
    chk("t6_data2", lk_data2, 0);
    chk("t6_stall_wen", WEN, 0);
    // third entry, then reset mid-drain with all sources asking
    set_src(1, 1'b1, 5'd9, 32'h999);
    #1;
    chk("t5_ready_fill", src_ready, 3'b010);
    tick();
    set_src(0, 1'b1, 5'd20, 32'h500);
    set_src(1, 1'b1, 5'd21, 32'h501);
    set_src(2, 1'b1, 5'd22, 32'h502);
    stall = 1'b0;
    chk("t5_pending_pre", pending, 1);
    nRST = 1'b0;
    #1;
    chk("t5_rst_wen", WEN, 0);
    chk("t5_rst_pending", pending, 0);
    chk("t5_rst_ready", src_ready, 0);
    chk("t5_rst_hit1", lk_hit1, 0);
    tick();
    chk("t5_rst_ready2", src_ready, 0);
    nRST = 1'b1;
    #1;
    chk("t5_first_grant", src_ready, 3'b001);
    tick();
    #1;
    chk("t5_second_grant", src_ready, 3'b010);
    chk("t5_wen", WEN, 1);
    chk("t5_wsel", wsel, 20);
    chk("t5_wdata", wdata, 32'h500);
    tick();
    src_valid = '0;
    #1;
    chk("t5_wsel2", wsel, 21);
    tick();
    chk("t5_drained", pending, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
